// File: rtl/spi_sram_pkg.sv
// Shared command codes, phase lengths and FSM states for the SPI SRAM responder.
// Pure declarations: no latency and no flow control.
package spi_sram_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_MASK  = 8'h7f;

  localparam int CMD_BITS        = 8;
  localparam int ADDR_PHASE_BITS = 24;

  localparam logic [4:0] CMD_LAST  = 5'(CMD_BITS - 1);
  localparam logic [4:0] ADDR_LAST = 5'(ADDR_PHASE_BITS - 1);
  localparam logic [4:0] BYTE_LAST = 5'd7;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RFETCH,
    RDATA,
    WDATA,
    IGNORE
  } state_t;

  function automatic logic [7:0] cmd_code(input logic [7:0] b);
    return b & CMD_MASK;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Pin synchronizer plus edge detector; strobes lag the pin by SYNC_STAGES+1 clk.
// No backpressure. Edges are suppressed until the chain has flushed after reset.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   primed_q;
  logic                   prev_q;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= {SYNC_STAGES{RESET_VAL}};
      prev_q   <= RESET_VAL;
      primed_q <= '0;
    end else begin
      sync_q   <= (sync_q << 1) | SYNC_STAGES'(pin);
      prev_q   <= level;
      primed_q <= (primed_q << 1) | (SYNC_STAGES + 1)'(1'b1);
    end
  end

  // The preset value draining out after reset must not look like a real edge.
  assign rise = primed_q[SYNC_STAGES] & level & ~prev_q;
  assign fall = primed_q[SYNC_STAGES] & ~level & prev_q;

endmodule

// File: rtl/spi_sram_slave.sv
// SPI mode-0 serial SRAM responder (0x02 write / 0x03 read, sequential addressing).
// First read bit ready within 3 clk of the last address rise strobe; no backpressure.
module spi_sram_slave
  import spi_sram_pkg::*;
#(
  parameter int ADDR_BITS   = 17,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sck,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic                 cmd_err
);

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // Same depth as the sck chain so mosi lines up with the rise strobe.
  always_ff @(posedge clk) begin
    if (rst) mosi_q <= '0;
    else     mosi_q <= (mosi_q << 1) | SYNC_STAGES'(mosi);
  end
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  state_t               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [7:0]           rx_q, rx_d;
  logic [7:0]           tx_q, tx_d;
  logic [7:0]           rbuf_q, rbuf_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 is_rd_q, is_rd_d;
  logic                 load_pend_q, load_pend_d;
  logic                 rd_dly_q;
  logic                 miso_d, mem_en_d, mem_wr_d, cmd_err_d;
  logic [7:0]           wdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rbuf_q      <= '0;
      addr_q      <= '0;
      is_rd_q     <= 1'b0;
      load_pend_q <= 1'b0;
      rd_dly_q    <= 1'b0;
      miso        <= 1'b0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_wdata   <= '0;
      cmd_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rbuf_q      <= rbuf_d;
      addr_q      <= addr_d;
      is_rd_q     <= is_rd_d;
      load_pend_q <= load_pend_d;
      rd_dly_q    <= mem_en & ~mem_wr;
      miso        <= miso_d;
      mem_en      <= mem_en_d;
      mem_wr      <= mem_wr_d;
      mem_wdata   <= wdata_d;
      cmd_err     <= cmd_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rbuf_d      = rbuf_q;
    addr_d      = addr_q;
    is_rd_d     = is_rd_q;
    load_pend_d = load_pend_q;
    miso_d      = miso;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    wdata_d     = mem_wdata;
    cmd_err_d   = 1'b0;

    // Post-write increment runs the cycle after the strobe so the strobe sees the old address.
    if (mem_en && mem_wr) addr_d = addr_q + ADDR_BITS'(1);
    if (rd_dly_q && state_q != RFETCH) rbuf_d = mem_rdata;

    if (cs_rise) begin
      state_d     = IDLE;
      miso_d      = 1'b0;
      load_pend_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d = CMD;
            cnt_d   = '0;
            miso_d  = 1'b0;
          end
        end
        CMD: begin
          if (sck_rise) begin
            rx_d  = {rx_q[6:0], mosi_s};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == CMD_LAST) begin
              cnt_d = '0;
              case (cmd_code(rx_d))
                CMD_WRITE: begin state_d = ADDR; is_rd_d = 1'b0; end
                CMD_READ:  begin state_d = ADDR; is_rd_d = 1'b1; end
                default:   begin state_d = IGNORE; cmd_err_d = 1'b1; end
              endcase
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            addr_d = {addr_q[ADDR_BITS-2:0], mosi_s};
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == ADDR_LAST) begin
              cnt_d = '0;
              if (is_rd_q) begin
                state_d  = RFETCH;
                mem_en_d = 1'b1;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RFETCH: begin
          if (rd_dly_q) begin
            miso_d      = mem_rdata[7];
            tx_d        = {mem_rdata[6:0], 1'b0};
            load_pend_d = 1'b0;
            state_d     = RDATA;
          end
        end
        RDATA: begin
          if (sck_rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == BYTE_LAST) begin
              cnt_d       = '0;
              addr_d      = addr_q + ADDR_BITS'(1);
              mem_en_d    = 1'b1;
              load_pend_d = 1'b1;
            end
          end else if (sck_fall) begin
            // The fall right after the address phase must not disturb the byte RFETCH loaded.
            if (cnt_q != 5'd0) begin
              miso_d = tx_q[7];
              tx_d   = {tx_q[6:0], 1'b0};
            end else if (load_pend_q) begin
              miso_d      = rbuf_q[7];
              tx_d        = {rbuf_q[6:0], 1'b0};
              load_pend_d = 1'b0;
            end
          end
        end
        WDATA: begin
          if (sck_rise) begin
            rx_d  = {rx_q[6:0], mosi_s};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == BYTE_LAST) begin
              cnt_d    = '0;
              mem_en_d = 1'b1;
              mem_wr_d = 1'b1;
              wdata_d  = rx_d;
            end
          end
        end
        IGNORE: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign mem_addr = addr_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_sram_slave.sv
// Directed bench for spi_sram_slave: drives an SPI master and models a byte-wide synchronous SRAM.
module tb_spi_sram_slave;
  localparam int AB   = 17;
  localparam int HALF = 6;

  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic miso, mem_en, mem_wr, busy, cmd_err;
  logic [AB-1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem [0:(1<<AB)-1];

  int chk_cnt = 0, pass_cnt = 0;
  int en_cnt = 0, en_dbl = 0, err_cnt = 0, miso_hi = 0;
  logic en_prev = 1'b0;
  logic [AB-1:0] wr_addr_q[$], rd_addr_q[$];
  logic [7:0] wr_data_q[$];

  always #5 clk = ~clk;

  spi_sram_slave #(.ADDR_BITS(AB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .cmd_err(cmd_err)
  );

  always @(posedge clk) begin
    if (mem_en && mem_wr) mem[mem_addr] = mem_wdata;
    if (mem_en && !mem_wr) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_en) begin
      en_cnt++;
      if (mem_wr) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
      end else begin
        rd_addr_q.push_back(mem_addr);
      end
    end
    if (mem_en && en_prev) en_dbl++;
    en_prev = mem_en;
    if (cmd_err) err_cnt++;
    if (miso) miso_hi++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      tick(HALF);
      rx[i] = miso;
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_end();
    tick(HALF);
    cs_n = 1'b1;
    tick(4 * HALF);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(5);
    chk_cnt++; if (miso !== 1'b0) $display("FAIL reset_miso got %0b want 0", miso); else pass_cnt++;
    chk_cnt++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en got %0b want 0", mem_en); else pass_cnt++;
    chk_cnt++; if (mem_wr !== 1'b0) $display("FAIL reset_mem_wr got %0b want 0", mem_wr); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 17'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else pass_cnt++;
    chk_cnt++; if (mem_wdata !== 8'h00) $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
    chk_cnt++; if (cmd_err !== 1'b0) $display("FAIL reset_cmd_err got %0b want 0", cmd_err); else pass_cnt++;
    rst = 1'b0;
    tick(10);
  endtask

  task automatic test_write();
    logic [7:0] rx;
    int en0;
    clear_log();
    en0 = en_cnt;
    cs_start();
    spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h10, rx);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL write_busy got %0b want 1", busy); else pass_cnt++;
    spi_byte(8'hA5, rx);
    tick(HALF);
    cs_n = 1'b1;
    tick(5);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL write_busy_after_cs got %0b want 0", busy); else pass_cnt++;
    tick(4 * HALF);
    chk_cnt++; if (en_cnt - en0 !== 1) $display("FAIL write_strobes got %0d want 1", en_cnt - en0); else pass_cnt++;
    chk_cnt++; if (wr_addr_q.size() !== 1) $display("FAIL write_count got %0d want 1", wr_addr_q.size()); else pass_cnt++;
    chk_cnt++; if (wr_addr_q[0] !== 17'h10) $display("FAIL write_addr got %h want 00010", wr_addr_q[0]); else pass_cnt++;
    chk_cnt++; if (wr_data_q[0] !== 8'hA5) $display("FAIL write_data got %h want a5", wr_data_q[0]); else pass_cnt++;
  endtask

  task automatic test_read();
    logic [7:0] rx;
    clear_log();
    mem[17'h10] = 8'hA5;
    cs_start();
    spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h10, rx);
    spi_byte(8'h00, rx);
    chk_cnt++; if (rx !== 8'hA5) $display("FAIL read_byte got %h want a5", rx); else pass_cnt++;
    chk_cnt++; if (rd_addr_q.size() < 1 || rd_addr_q[0] !== 17'h10) $display("FAIL read_addr got %h want 00010", rd_addr_q[0]); else pass_cnt++;
    cs_end();
    chk_cnt++; if (miso !== 1'b0) $display("FAIL read_miso_idle got %0b want 0", miso); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL read_busy_idle got %0b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_seq_write_wrap();
    logic [7:0] rx;
    logic [AB-1:0] exp_a [4] = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
    logic [7:0]    exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_log();
    cs_start();
    spi_byte(8'h02, rx); spi_byte(8'h01, rx); spi_byte(8'hFF, rx); spi_byte(8'hFE, rx);
    for (int k = 0; k < 4; k++) spi_byte(exp_d[k], rx);
    cs_end();
    chk_cnt++; if (wr_addr_q.size() !== 4) $display("FAIL wrap_count got %0d want 4", wr_addr_q.size()); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      chk_cnt++; if (wr_addr_q[k] !== exp_a[k]) $display("FAIL wrap_addr%0d got %h want %h", k, wr_addr_q[k], exp_a[k]); else pass_cnt++;
      chk_cnt++; if (wr_data_q[k] !== exp_d[k]) $display("FAIL wrap_data%0d got %h want %h", k, wr_data_q[k], exp_d[k]); else pass_cnt++;
    end
  endtask

  task automatic test_seq_read();
    logic [7:0] rx;
    logic [7:0] got [3];
    logic [7:0] exp_d [3] = '{8'h3C, 8'hC3, 8'h5A};
    int dbl0;
    clear_log();
    dbl0 = en_dbl;
    mem[17'h20] = 8'h3C; mem[17'h21] = 8'hC3; mem[17'h22] = 8'h5A; mem[17'h23] = 8'h0F;
    cs_start();
    spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h20, rx);
    for (int k = 0; k < 3; k++) spi_byte(8'h00, got[k]);
    cs_end();
    for (int k = 0; k < 3; k++) begin
      chk_cnt++; if (got[k] !== exp_d[k]) $display("FAIL seqrd_byte%0d got %h want %h", k, got[k], exp_d[k]); else pass_cnt++;
    end
    chk_cnt++; if (rd_addr_q.size() !== 4) $display("FAIL seqrd_strobes got %0d want 4", rd_addr_q.size()); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      chk_cnt++; if (rd_addr_q[k] !== AB'(32 + k)) $display("FAIL seqrd_addr%0d got %h want %h", k, rd_addr_q[k], AB'(32 + k)); else pass_cnt++;
    end
    chk_cnt++; if (en_dbl - dbl0 !== 0) $display("FAIL seqrd_wide_strobe got %0d want 0", en_dbl - dbl0); else pass_cnt++;
  endtask

  task automatic test_bad_cmd();
    logic [7:0] rx, rx1, rx2;
    int en0, err0, hi0;
    en0 = en_cnt; err0 = err_cnt; hi0 = miso_hi;
    cs_start();
    spi_byte(8'h05, rx);
    tick(2);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL badcmd_busy got %0b want 1", busy); else pass_cnt++;
    spi_byte(8'hFF, rx1);
    spi_byte(8'hFF, rx2);
    chk_cnt++; if (err_cnt - err0 !== 1) $display("FAIL badcmd_err_cycles got %0d want 1", err_cnt - err0); else pass_cnt++;
    cs_end();
    chk_cnt++; if (en_cnt - en0 !== 0) $display("FAIL badcmd_strobes got %0d want 0", en_cnt - en0); else pass_cnt++;
    chk_cnt++; if (miso_hi - hi0 !== 0) $display("FAIL badcmd_miso_high got %0d want 0", miso_hi - hi0); else pass_cnt++;
    chk_cnt++; if ({rx1, rx2} !== 16'h0000) $display("FAIL badcmd_rx got %h want 0000", {rx1, rx2}); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL badcmd_busy_end got %0b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_abort_and_rst();
    logic [7:0] rx;
    int en0;
    clear_log();
    en0 = en_cnt;
    cs_start();
    spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h40, rx);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1; tick(HALF); sck = 1'b1; tick(HALF); sck = 1'b0;
    end
    cs_end();
    chk_cnt++; if (en_cnt - en0 !== 0) $display("FAIL abort_strobes got %0d want 0", en_cnt - en0); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %0b want 0", busy); else pass_cnt++;

    mem[17'h10] = 8'hA5;
    cs_start();
    spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h10, rx);
    for (int i = 0; i < 3; i++) begin
      tick(HALF); sck = 1'b1; tick(HALF); sck = 1'b0;
    end
    rst = 1'b1;
    tick(3);
    chk_cnt++; if (miso !== 1'b0) $display("FAIL rst_miso got %0b want 0", miso); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 17'h0) $display("FAIL rst_mem_addr got %h want 0", mem_addr); else pass_cnt++;
    chk_cnt++; if (mem_wdata !== 8'h00) $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); else pass_cnt++;
    chk_cnt++; if ({mem_en, mem_wr, busy, cmd_err} !== 4'b0000) $display("FAIL rst_flags got %b want 0000", {mem_en, mem_wr, busy, cmd_err}); else pass_cnt++;
    rst = 1'b0;
    tick(10);
    en0 = en_cnt;
    spi_byte(8'h02, rx);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_no_restart got %0b want 0", busy); else pass_cnt++;
    cs_end();
    clear_log();
    cs_start();
    spi_byte(8'h02, rx);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL restart_busy got %0b want 1", busy); else pass_cnt++;
    spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h30, rx); spi_byte(8'h5A, rx);
    cs_end();
    chk_cnt++; if (wr_addr_q.size() !== 1) $display("FAIL restart_count got %0d want 1", wr_addr_q.size()); else pass_cnt++;
    chk_cnt++; if (wr_addr_q[0] !== 17'h30 || wr_data_q[0] !== 8'h5A) $display("FAIL restart_write got %h:%h want 00030:5a", wr_addr_q[0], wr_data_q[0]); else pass_cnt++;
    chk_cnt++; if (en_dbl !== 0) $display("FAIL strobe_width got %0d want 0", en_dbl); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_seq_write_wrap();
    test_seq_read();
    test_bad_cmd();
    test_abort_and_rst();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/spi_sram_slave.md
Name: spi_sram_slave

Overview:
- SPI-mode-0 serial SRAM responder. It decodes the 0x02 write and 0x03 read sequences issued by the team's SPI SRAM master.
- A byte-wide synchronous memory port sits behind it. It is used in simulation and on FPGA to stand in for an external 23LC-class part.
- SCK, CS_N and MOSI are oversampled in the clk domain. clk runs at 8x SCK or faster.
- Sequential mode: the address auto-increments per data byte for as long as CS_N stays low.

Parameters:
- ADDR_BITS, 17: number of decoded address bits. Upper bits of the 24-bit address are ignored.
- SYNC_STAGES, 2: synchronizer depth on sck, cs_n and mosi.

Ports:
- clk  input  1  oversampling clock, at least 8x SCK
- rst  input  1  synchronous, active-high reset
- sck  input  1  SPI clock, idles low (mode 0)
- cs_n  input  1  SPI chip select, active low
- mosi  input  1  SPI serial data in
- miso  output  1  SPI serial data out
- mem_addr  output  ADDR_BITS  memory address
- mem_en  output  1  one-cycle memory access strobe
- mem_wr  output  1  write qualifier for mem_en
- mem_wdata  output  8  write data
- mem_rdata  input  8  read data, valid exactly one clk after a read strobe
- busy  output  1  high while CS_N is low and a transaction is active
- cmd_err  output  1  one-cycle pulse when an unsupported command byte is received

Behaviour:
- Reset values: miso=0, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, busy=0, cmd_err=0. State is IDLE; synchronizers preset to sck=0, cs_n=1.
- Input conditioning: SYNC_STAGES flops per input, then one edge-detect stage. rise/fall strobes are single-cycle and lag the pin by SYNC_STAGES+1 clk.
- Bit timing: MOSI is sampled on each rise strobe, MSB first. MISO changes only on a fall strobe or when a byte is loaded.
- IDLE:
  - Falling edge of cs_n -> CMD, bit counter = 0.
  - After rst, an already-low cs_n does not start a transaction. cs_n must be seen high first.
- CMD: after 8 bits, decode cmd[6:0] (bit 7 don't care).
  - 0x02 -> ADDR (write).
  - 0x03 -> ADDR (read).
  - Any other value -> cmd_err pulse, then IGNORE.
- ADDR: after 24 bits, latch addr[ADDR_BITS-1:0].
  - Write -> WDATA.
  - Read -> RFETCH.
- RFETCH: mem_en=1, mem_wr=0 for one clk. Next clk: capture mem_rdata into the shift register and drive bit 7 onto miso. Then go to RDATA.
  - This completes within 3 clk of the 32nd rise, before the next fall strobe, which is guaranteed by the 8x ratio.
- RDATA:
  - On each fall strobe, shift out the next bit.
  - On the 8th rise of a byte, increment the address (wrap modulo 2^ADDR_BITS) and issue the read strobe for the next byte.
  - The next byte is loaded at that byte's first fall strobe, so the stream is gapless.
- WDATA: after each 8 received bits:
  - One-clk mem_en=1, mem_wr=1, with mem_wdata=byte and mem_addr=current address.
  - Then increment the address, wrapping at 2^ADDR_BITS.
- IGNORE: miso=0, no memory strobes, until cs_n rises.
- CS_N rise in any state:
  - Return to IDLE on the clk it is detected (within SYNC_STAGES+1 clk of the pin).
  - A partial write byte is discarded with no write strobe.
  - miso=0, busy=0.
- busy is high in CMD, ADDR, RFETCH, RDATA, WDATA and IGNORE.
- Simultaneous events: cs_n rise has priority over a coincident rise/fall strobe.
- rst mid-transaction: immediate IDLE with all outputs at reset values. Requires a cs_n high, then low, to restart.
- mem_en is never high for more than one consecutive clk.

Decomposition:
- Package spi_sram_pkg holds:
  - CMD_WRITE=8'h02, CMD_READ=8'h03, CMD_MASK=8'h7f.
  - State enum typedef (IDLE, CMD, ADDR, RFETCH, RDATA, WDATA, IGNORE).
  - Constants ADDR_PHASE_BITS=24 and CMD_BITS=8.
- One sub-module, spi_pin_sync: a SYNC_STAGES synchronizer plus edge detector, instanced for sck and cs_n. mosi uses the synchronizer only.

Test Plan:
- Write 0x02, addr 0x000010, data 0xA5 -> exactly one write strobe, mem_addr=0x10, mem_wdata=0xA5, mem_wr=1; busy falls after cs_n rises.
- Read 0x03, addr 0x000010, with memory model returning 0xA5 -> miso shifts 1,0,1,0,0,1,0,1 on successive rising SCK edges.
- Sequential write of 4 bytes 11,22,33,44 from addr 0x1FFFE (ADDR_BITS=17) -> writes land at 0x1FFFE, 0x1FFFF, 0x00000 and 0x00001 (wrap).
- Sequential read of 3 bytes from addr 0x20 -> read strobes at 0x20, 0x21, 0x22, each one clk wide; the miso stream has no gap bits between bytes.
- Command 0x05, then 16 SCK clocks -> cmd_err one-clk pulse, no mem_en, miso=0 throughout.
- Write with cs_n raised after 5 data bits, then rst asserted mid-read while cs_n is low -> no write strobe; after rst, outputs are at reset values and a new transaction starts only after a cs_n high-to-low edge.
